stopwatch_core: RTL and testbench

BCD stopwatch counter that consumes the 100 Hz square wave from the hundredth-second divider. It counts hundredths, seconds and minutes in BCD, and runs a start/stop/lap/clear control FSM. It feeds the seven-segment display driver. It is clocked by the same 2 MHz system clock as the divider, so no synchronizer is needed on the 100 Hz input.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/bcd_digit_counter.sv | 64 ++++++
 rtl/stopwatch_core.sv | 161 ++++++++++++++++
 tb/tb_stopwatch_core.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: definitions shared by the stopwatch core and its digit counters.
//   stopwatch_state_e : control FSM states
//   HUN_MOD, SEC_MOD  : moduli for the hundredths and seconds digit pairs
//   bcd_time_t        : six BCD digits (mm:ss.hh), used for live count and lap
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } stopwatch_state_e;

  localparam int HUN_MOD = 100;
  localparam int SEC_MOD = 60;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic [3:0] hun_t;
    logic [3:0] hun_o;
  } bcd_time_t;

endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: mod-MOD two-digit BCD counter (MOD in 1..100).
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance by one this cycle
//   clr        : synchronous clear, wins over inc
//   tens, ones : BCD count
//   carry_out  : combinational, high when inc rolls the pair from MOD-1 to 0,
//                so a chain of these ripples within one cycle
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MOD = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry_out
);

  localparam logic [3:0] MAX_T = 4'((MOD - 1) / 10);
  localparam logic [3:0] MAX_O = 4'((MOD - 1) % 10);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       at_max;

  assign at_max    = (tens_q == MAX_T) && (ones_q == MAX_O);
  assign carry_out = inc && at_max && !clr;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (inc) begin
      if (at_max) begin
        tens_d = 4'd0;
        ones_d = 4'd0;
      end else if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD stopwatch (mm:ss.hh) driven by the 100 Hz divider output,
// with start/stop and lap/clear control.
//   clk_2MHz, reset_n      : system clock, asynchronous active-low reset
//   clk_100Hz              : divider square wave, one hundredth per rising edge
//   btn_start_stop (ss)    : debounced level, acts on rising edge
//   btn_lap_clear  (lc)    : debounced level, acts on rising edge
//   min/sec/hun _t/_o      : displayed BCD digits (lap register while in LAP)
//   running, lap_active    : RUN or LAP / LAP only
//   wrap                   : one-cycle pulse when the count rolls to 00:00.00
//
// state | meaning
// IDLE  | stopped at zero, lc re-clears
// RUN   | counting, live count displayed
// PAUSE | stopped, count held, lc clears everything
// LAP   | counting, frozen lap value displayed
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int MINUTE_WRAP = 60
) (
  input  logic       clk_2MHz,
  input  logic       reset_n,
  input  logic       clk_100Hz,
  input  logic       btn_start_stop,
  input  logic       btn_lap_clear,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [3:0] hun_t,
  output logic [3:0] hun_o,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  logic c100_q, ss_q, lc_q;
  logic tick, ss_ev, lc_ev;

  stopwatch_state_e state_q;
  bcd_time_t        lap_q;
  bcd_time_t        live;
  bcd_time_t        disp;
  logic             running_q, lap_active_q, wrap_q;

  logic count_en, clr_live;
  logic hun_carry, sec_carry, min_carry;

  assign tick  = clk_100Hz & ~c100_q;
  assign ss_ev = btn_start_stop & ~ss_q;
  assign lc_ev = btn_lap_clear & ~lc_q;

  // Counting uses the pre-update state: a tick on RUN->PAUSE counts,
  // a tick on PAUSE->RUN does not.
  assign count_en = tick && ((state_q == RUN) || (state_q == LAP));
  // ss has priority, so lc only clears when ss is absent.
  assign clr_live = lc_ev && !ss_ev && ((state_q == IDLE) || (state_q == PAUSE));

  bcd_digit_counter #(.MOD(HUN_MOD)) u_hun (
    .clk       (clk_2MHz),
    .rst_n     (reset_n),
    .inc       (count_en),
    .clr       (clr_live),
    .tens      (live.hun_t),
    .ones      (live.hun_o),
    .carry_out (hun_carry)
  );

  bcd_digit_counter #(.MOD(SEC_MOD)) u_sec (
    .clk       (clk_2MHz),
    .rst_n     (reset_n),
    .inc       (hun_carry),
    .clr       (clr_live),
    .tens      (live.sec_t),
    .ones      (live.sec_o),
    .carry_out (sec_carry)
  );

  bcd_digit_counter #(.MOD(MINUTE_WRAP)) u_min (
    .clk       (clk_2MHz),
    .rst_n     (reset_n),
    .inc       (sec_carry),
    .clr       (clr_live),
    .tens      (live.min_t),
    .ones      (live.min_o),
    .carry_out (min_carry)
  );

  always_ff @(posedge clk_2MHz or negedge reset_n) begin
    if (!reset_n) begin
      c100_q       <= 1'b0;
      ss_q         <= 1'b0;
      lc_q         <= 1'b0;
      state_q      <= IDLE;
      lap_q        <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      c100_q <= clk_100Hz;
      ss_q   <= btn_start_stop;
      lc_q   <= btn_lap_clear;
      wrap_q <= min_carry;
      case (state_q)
        IDLE: begin
          if (ss_ev) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (ss_ev) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end else if (lc_ev) begin
            state_q      <= LAP;
            lap_q        <= live;
            lap_active_q <= 1'b1;
          end
        end
        LAP: begin
          if (ss_ev) begin
            state_q      <= PAUSE;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
          end else if (lc_ev) begin
            state_q      <= RUN;
            lap_active_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (ss_ev) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end else if (lc_ev) begin
            state_q <= IDLE;
            lap_q   <= '0;
          end
        end
        default: begin
          state_q      <= IDLE;
          running_q    <= 1'b0;
          lap_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign disp = (state_q == LAP) ? lap_q : live;

  assign min_t      = disp.min_t;
  assign min_o      = disp.min_o;
  assign sec_t      = disp.sec_t;
  assign sec_o      = disp.sec_o;
  assign hun_t      = disp.hun_t;
  assign hun_o      = disp.hun_o;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
`timescale 1ns/1ps
module tb_stopwatch_core;

  // Small minute modulus keeps the full-wrap walk short: wrap after 01:59.99.
  localparam int MW = 2;

  logic       clk_2MHz = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk_100Hz = 1'b0;
  logic       btn_start_stop = 1'b0;
  logic       btn_lap_clear = 1'b0;
  logic [3:0] min_t, min_o, sec_t, sec_o, hun_t, hun_o;
  logic       running, lap_active, wrap;
  logic [23:0] disp;

  stopwatch_core #(.MINUTE_WRAP(MW)) dut (
    .clk_2MHz       (clk_2MHz),
    .reset_n        (reset_n),
    .clk_100Hz      (clk_100Hz),
    .btn_start_stop (btn_start_stop),
    .btn_lap_clear  (btn_lap_clear),
    .min_t          (min_t),
    .min_o          (min_o),
    .sec_t          (sec_t),
    .sec_o          (sec_o),
    .hun_t          (hun_t),
    .hun_o          (hun_o),
    .running        (running),
    .lap_active     (lap_active),
    .wrap           (wrap)
  );

  assign disp = {min_t, min_o, sec_t, sec_o, hun_t, hun_o};

  always #250 clk_2MHz = ~clk_2MHz;

  int cycle = 0;
  always @(posedge clk_2MHz) cycle++;

  typedef struct {
    int          cyc;
    string       name;
    logic [23:0] disp;
    logic        run;
    logic        lap;
    logic        wrp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Scoreboard push: the expected snapshot is due at the falling edge of
  // the cycle dly cycles from now.
  task automatic expect_at(input int dly, input string name, input logic [23:0] d,
                           input logic r, input logic l, input logic w);
    exp_t e;
    e.cyc  = cycle + dly;
    e.name = name;
    e.disp = d;
    e.run  = r;
    e.lap  = l;
    e.wrp  = w;
    exp_q.push_back(e);
  endtask

  // Monitor: pops every due entry and compares against the DUT outputs.
  always @(negedge clk_2MHz) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
      e = exp_q.pop_front();
      n_checks++;
      if (e.cyc < cycle) begin
        n_fail++;
        $display("FAIL %s: check missed, due cycle %0d now %0d", e.name, e.cyc, cycle);
      end else if (disp !== e.disp || running !== e.run || lap_active !== e.lap || wrap !== e.wrp) begin
        n_fail++;
        $display("FAIL %s: got disp=%h running=%b lap=%b wrap=%b, expected disp=%h running=%b lap=%b wrap=%b",
                 e.name, disp, running, lap_active, wrap, e.disp, e.run, e.lap, e.wrp);
      end
    end
  end

  task automatic step();
    @(posedge clk_2MHz);
    #1;
  endtask

  // One divider period squeezed to two clocks; the count updates on the
  // second edge, so outputs are final when this returns.
  task automatic ticks(input int n);
    repeat (n) begin
      step();
      clk_100Hz = 1'b1;
      step();
      clk_100Hz = 1'b0;
    end
  endtask

  // Buttons are held for three edges to confirm a held level is one event;
  // an optional tick rises in the same cycle as the button edge.
  task automatic press(input logic ss, input logic lc, input logic tk);
    step();
    btn_start_stop = ss;
    btn_lap_clear  = lc;
    clk_100Hz      = tk;
    step();
    clk_100Hz = 1'b0;
    step();
    step();
    btn_start_stop = 1'b0;
    btn_lap_clear  = 1'b0;
  endtask

  initial begin
    #30_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    expect_at(0, "reset_state", 24'h000000, 1'b0, 1'b0, 1'b0);
    step();
    reset_n = 1'b1;

    ticks(3);
    expect_at(0, "idle_ignores_tick", 24'h000000, 1'b0, 1'b0, 1'b0);

    press(1'b1, 1'b0, 1'b0);
    expect_at(0, "start", 24'h000000, 1'b1, 1'b0, 1'b0);
    ticks(150);
    expect_at(0, "count_150", 24'h000150, 1'b1, 1'b0, 1'b0);

    ticks(175);
    expect_at(0, "count_325", 24'h000325, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    expect_at(0, "lap_capture", 24'h000325, 1'b1, 1'b1, 1'b0);
    ticks(100);
    expect_at(0, "lap_frozen", 24'h000325, 1'b1, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    expect_at(0, "lap_release", 24'h000425, 1'b1, 1'b0, 1'b0);

    press(1'b1, 1'b0, 1'b0);
    expect_at(0, "pause_425", 24'h000425, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    expect_at(0, "clear_from_pause", 24'h000000, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    expect_at(0, "restart", 24'h000000, 1'b1, 1'b0, 1'b0);
    ticks(200);
    expect_at(0, "count_200", 24'h000200, 1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    expect_at(0, "pause_200", 24'h000200, 1'b0, 1'b0, 1'b0);
    ticks(50);
    expect_at(0, "pause_holds", 24'h000200, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    expect_at(0, "clear_to_idle", 24'h000000, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    expect_at(0, "resume_from_zero", 24'h000000, 1'b1, 1'b0, 1'b0);

    ticks(7);
    expect_at(0, "count_7", 24'h000007, 1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    expect_at(0, "ss_lc_same_cycle", 24'h000007, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b1);
    expect_at(0, "tick_on_pause_to_run", 24'h000007, 1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b1);
    expect_at(0, "tick_on_run_to_pause", 24'h000008, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b1);
    expect_at(0, "clear_with_tick", 24'h000000, 1'b0, 1'b0, 1'b0);

    press(1'b1, 1'b0, 1'b0);
    ticks(5999);
    expect_at(0, "count_5999", 24'h005999, 1'b1, 1'b0, 1'b0);
    ticks(1);
    expect_at(0, "minute_carry", 24'h010000, 1'b1, 1'b0, 1'b0);
    ticks(5999);
    expect_at(0, "count_15999", 24'h015999, 1'b1, 1'b0, 1'b0);
    ticks(1);
    expect_at(0, "wrap_pulse", 24'h000000, 1'b1, 1'b0, 1'b1);
    expect_at(1, "wrap_one_cycle", 24'h000000, 1'b1, 1'b0, 1'b0);

    ticks(742);
    expect_at(0, "count_742", 24'h000742, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    ticks(3);
    expect_at(0, "lap_742", 24'h000742, 1'b1, 1'b1, 1'b0);
    step();
    reset_n = 1'b0;
    expect_at(0, "async_reset", 24'h000000, 1'b0, 1'b0, 1'b0);
    step();
    step();
    reset_n = 1'b1;
    ticks(5);
    expect_at(0, "idle_after_reset", 24'h000000, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    ticks(1);
    expect_at(0, "run_after_reset", 24'h000001, 1'b1, 1'b0, 1'b0);

    repeat (4) step();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d checks left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
